// File: rtl/button_conditioner.sv
// Two-channel pushbutton conditioner: synchronizes, debounces and edge-detects
// active-low buttons, producing debounced levels, press pulses and a both-held flag.
module button_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 500_000,
    parameter int unsigned CNT_W           = 20
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_right_n,
    input  logic raw_left_n,
    output logic right_button,
    output logic left_button,
    output logic right_press,
    output logic left_press,
    output logic both_held
);

    localparam int unsigned NUM_CH = 2;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

    typedef enum logic [1:0] {
        RELEASED,
        PRESS_PEND,
        HELD,
        REL_PEND
    } state_t;

    logic [NUM_CH-1:0] raw_n;
    logic [NUM_CH-1:0] level;
    logic [NUM_CH-1:0] press;

    assign raw_n = {raw_left_n, raw_right_n};

    // Channel 0 is right, channel 1 is left; both are identical and independent.
    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
        logic             sync1_q;
        logic             sync2_q;
        state_t           state_q;
        state_t           state_d;
        logic [CNT_W-1:0] cnt_q;
        logic [CNT_W-1:0] cnt_d;
        logic             level_q;
        logic             press_q;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                sync1_q <= 1'b1;
                sync2_q <= 1'b1;
            end else begin
                sync1_q <= raw_n[ch];
                sync2_q <= sync1_q;
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                state_q <= RELEASED;
                cnt_q   <= '0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
            end
        end

        // Counter only advances while below CNT_MAX, so it cannot wrap.
        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            case (state_q)
                RELEASED: begin
                    if (!sync2_q) begin
                        state_d = PRESS_PEND;
                        cnt_d   = CNT_W'(1);
                    end else begin
                        cnt_d = '0;
                    end
                end
                PRESS_PEND: begin
                    if (sync2_q) begin
                        state_d = RELEASED;
                        cnt_d   = '0;
                    end else if (cnt_q == CNT_MAX) begin
                        state_d = HELD;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                HELD: begin
                    if (sync2_q) begin
                        state_d = REL_PEND;
                        cnt_d   = CNT_W'(1);
                    end
                end
                REL_PEND: begin
                    if (!sync2_q) begin
                        state_d = HELD;
                        cnt_d   = '0;
                    end else if (cnt_q == CNT_MAX) begin
                        state_d = RELEASED;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_d = RELEASED;
                    cnt_d   = '0;
                end
            endcase
        end

        // Level and pulse are registered from the next state so they change with the transition.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                level_q <= 1'b1;
                press_q <= 1'b0;
            end else begin
                level_q <= !((state_d == HELD) || (state_d == REL_PEND));
                press_q <= (state_q == PRESS_PEND) && (state_d == HELD);
            end
        end

        assign level[ch] = level_q;
        assign press[ch] = press_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            both_held <= 1'b0;
        end else begin
            both_held <= !level[0] && !level[1];
        end
    end

    assign right_button = level[0];
    assign left_button  = level[1];
    assign right_press  = press[0];
    assign left_press   = press[1];

endmodule

// File: tb/tb_button_conditioner.sv
// Scoreboard bench for button_conditioner with DEBOUNCE_CYCLES=4: expected output
// vectors are queued per cycle as stimulus is driven and compared by a cycle monitor.
module tb_button_conditioner;

    localparam int unsigned DC = 4;

    logic clk = 1'b0;
    logic rst;
    logic raw_right_n;
    logic raw_left_n;
    logic right_button;
    logic left_button;
    logic right_press;
    logic left_press;
    logic both_held;

    button_conditioner #(
        .DEBOUNCE_CYCLES(DC),
        .CNT_W          (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .raw_right_n (raw_right_n),
        .raw_left_n  (raw_left_n),
        .right_button(right_button),
        .left_button (left_button),
        .right_press (right_press),
        .left_press  (left_press),
        .both_held   (both_held)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic [4:0] outs;
        string      tag;
    } exp_t;

    exp_t       sb[$];
    int         cyc = 0;
    int         n_tests = 0;
    int         n_fail = 0;
    logic [4:0] outs;

    assign outs = {both_held, left_press, right_press, left_button, right_button};

    // Vector layout {both_held, left_press, right_press, left_button, right_button}.
    function automatic logic [4:0] vec(input logic rb, input logic lb, input logic rp,
                                       input logic lp, input logic bh);
        return {bh, lp, rp, lb, rb};
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got 0x%0h expected 0x%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic push(input int c, input logic [4:0] v, input string tag);
        exp_t e;
        e.cyc  = c;
        e.outs = v;
        e.tag  = tag;
        sb.push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() > 0 && n < 60) begin
            @(posedge clk);
            n++;
        end
        #2;
        check_eq("sb_drain", 32'(sb.size()), 32'd0);
        sb.delete();
        step(2);
    endtask

    // Monitor: sample #1 after each rising edge and retire due scoreboard entries.
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            while (sb.size() > 0 && sb[0].cyc <= cyc) begin
                exp_t e;
                e = sb.pop_front();
                check_eq({e.tag, "_cyc"}, 32'(cyc), 32'(e.cyc));
                check_eq(e.tag, 32'(outs), 32'(e.outs));
            end
        end
    end

    initial begin
        int         p;
        logic [4:0] rst_v;
        logic [4:0] idle_v;
        rst_v       = vec(1, 1, 0, 0, 0);
        idle_v      = rst_v;
        rst         = 1'b1;
        raw_right_n = 1'b1;
        raw_left_n  = 1'b1;

        step(2);
        push(cyc + 1, rst_v, "reset_vals");
        step(2);
        rst = 1'b0;
        push(cyc + 1, idle_v, "idle");
        drain();

        // Clean right press
        p = cyc;
        raw_right_n = 1'b0;
        push(p + 6, idle_v,               "s1_before");
        push(p + 7, vec(0, 1, 1, 0, 0),   "s1_press");
        push(p + 8, vec(0, 1, 0, 0, 0),   "s1_held");
        drain();

        // Release glitch of two cycles must be rejected
        p = cyc;
        raw_right_n = 1'b1;
        step(2);
        raw_right_n = 1'b0;
        for (int i = 3; i <= 10; i++) push(p + i, vec(0, 1, 0, 0, 0), "s3_glitch");
        drain();

        // Stable release: no pulse
        p = cyc;
        raw_right_n = 1'b1;
        push(p + 6, vec(0, 1, 0, 0, 0), "s3_rel_before");
        push(p + 7, idle_v,             "s3_rel");
        push(p + 8, idle_v,             "s3_rel_nopulse");
        drain();

        // Left bounce: low 3, high 1, low held
        p = cyc;
        raw_left_n = 1'b0;
        for (int i = 1; i <= 10; i++) push(p + i, idle_v, "s2_bounce");
        step(3);
        raw_left_n = 1'b1;
        step(1);
        raw_left_n = 1'b0;
        push(p + 11, vec(1, 0, 0, 1, 0), "s2_press");
        push(p + 12, vec(1, 0, 0, 0, 0), "s2_held");
        drain();

        p = cyc;
        raw_left_n = 1'b1;
        push(p + 6, vec(1, 0, 0, 0, 0), "s2_rel_before");
        push(p + 7, idle_v,             "s2_rel");
        drain();

        // Simultaneous press and release
        p = cyc;
        raw_right_n = 1'b0;
        raw_left_n  = 1'b0;
        push(p + 6, idle_v,             "s4_before");
        push(p + 7, vec(0, 0, 1, 1, 0), "s4_press");
        push(p + 8, vec(0, 0, 0, 0, 1), "s4_both");
        push(p + 9, vec(0, 0, 0, 0, 1), "s4_both_hold");
        drain();

        p = cyc;
        raw_right_n = 1'b1;
        raw_left_n  = 1'b1;
        push(p + 6, vec(0, 0, 0, 0, 1), "s4_rel_before");
        push(p + 7, vec(1, 1, 0, 0, 1), "s4_rel_lag");
        push(p + 8, idle_v,             "s4_rel_done");
        drain();

        // Reset three cycles into a press, then re-debounce with raw still low
        p = cyc;
        raw_right_n = 1'b0;
        step(3);
        rst = 1'b1;
        #1;
        check_eq("s5_rst_async", 32'(outs), 32'(rst_v));
        push(p + 4, rst_v, "s5_in_rst");
        push(p + 5, rst_v, "s5_in_rst");
        step(2);
        rst = 1'b0;
        p = cyc;
        for (int i = 1; i <= 6; i++) push(p + i, idle_v, "s5_redebounce");
        push(p + 7, vec(0, 1, 1, 0, 0), "s5_press");
        push(p + 8, vec(0, 1, 0, 0, 0), "s5_held");
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end

endmodule
